// File: rtl/debounce_loader_if.sv
// Load-side handshake between debounce_loader and the countdown stage.
//   ready : one-cycle load pulse
//   value : captured switch value (valid with ready, held between pulses)
//   level : debounced button level
interface debounce_loader_if;
  logic       ready;
  logic [7:0] value;
  logic       level;

  modport master (output ready, output value, output level);
  modport slave  (input  ready, input  value, input  level);
endinterface

// File: rtl/debounce_loader.sv
// debounce_loader: synchronises and debounces a raw push-button, emits a
// single-cycle load pulse per debounced press and captures the synchronised
// 8-bit switch bank on that pulse.
// Optional macro AUTO_REPEAT_EN: a held button re-pulses every
// REPEAT_CYCLES cycles after the initial press pulse.
module debounce_loader #(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_CYCLES = 256
) (
  input  logic              i_w_clk,
  input  logic              i_w_reset,
  input  logic              i_w_button,
  input  logic [7:0]        i_w_switches,
  debounce_loader_if.master load
);

  if (STABLE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("debounce_loader: STABLE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          btn_s1, btn_s2;
  logic [7:0]    sw_s1, sw_s2;
  logic          ready;
  logic [7:0]    value;
  logic          level;

`ifdef AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep;
`endif

  // Two-flop synchronisers for the asynchronous button and switch inputs
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= i_w_button;
      btn_s2 <= btn_s1;
      sw_s1  <= i_w_switches;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce FSM with registered pulse, captured value and level
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state <= S_LOW;
      cnt   <= '0;
      ready <= 1'b0;
      value <= '0;
      level <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep   <= '0;
`endif
    end else begin
      ready <= 1'b0;
      unique case (state)
        S_LOW: begin
          if (btn_s2) begin
            state <= S_RISE_CHK;
            cnt   <= '0;
          end
        end
        S_RISE_CHK: begin
          if (!btn_s2) begin
            state <= S_LOW;
          end else if (cnt == CNT_LAST) begin
            state <= S_HIGH;
            ready <= 1'b1;
            value <= sw_s2;
            level <= 1'b1;
`ifdef AUTO_REPEAT_EN
            rep   <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!btn_s2) begin
            state <= S_FALL_CHK;
            cnt   <= '0;
          end
`ifdef AUTO_REPEAT_EN
          // Counter only advances while the button stays high, so a release
          // never fires a stray repeat; the !ready guard keeps pulses apart.
          else if (rep == REP_LAST) begin
            rep <= '0;
            if (!ready) begin
              ready <= 1'b1;
              value <= sw_s2;
            end
          end else begin
            rep <= rep + 1'b1;
          end
`endif
        end
        S_FALL_CHK: begin
          if (btn_s2) begin
            state <= S_HIGH;
          end else if (cnt == CNT_LAST) begin
            state <= S_LOW;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_LOW;
      endcase
    end
  end

  assign load.ready = ready;
  assign load.value = value;
  assign load.level = level;

endmodule

// File: tb/tb_debounce_loader.sv
// Testbench for debounce_loader (STABLE_CYCLES=4, REPEAT_CYCLES=8).
// Every clock edge is checked against a run-length reference model; a table
// of directed segments and hand-written latency sequences add fixed checks.
module tb_debounce_loader;

  localparam int STABLE = 4;
  localparam int REPEAT = 8;
`ifdef AUTO_REPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic       clk;
  logic       rst;
  logic       btn;
  logic [7:0] sw;

  debounce_loader_if lif ();

  debounce_loader #(
    .STABLE_CYCLES(STABLE),
    .REPEAT_CYCLES(REPEAT)
  ) dut (
    .i_w_clk     (clk),
    .i_w_reset   (rst),
    .i_w_button  (btn),
    .i_w_switches(sw),
    .load        (lif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: synchronised sample = raw input two edges ago; the
  // debounced level flips once STABLE+1 consecutive samples disagree with it.
  bit         mb1, mb2, mL, mready;
  logic [7:0] mw1, mw2, mvalue;
  int         mrun, mrep;

  task automatic model_edge();
    bit s;
    bit nr;
    int run_old;
    if (rst) begin
      mb1 = 0; mb2 = 0; mw1 = '0; mw2 = '0;
      mL = 0; mready = 0; mvalue = '0; mrun = 0; mrep = 0;
    end else begin
      s = mb2;
      nr = 0;
      run_old = mrun;
      if (s != mL) begin
        mrun++;
        if (mrun == STABLE + 1) begin
          mL = s;
          mrun = 0;
          if (s) begin
            nr = 1;
            mvalue = mw2;
            mrep = 0;
          end
        end
      end else begin
        mrun = 0;
        if (AR == 1 && mL && run_old == 0) begin
          if (mrep == REPEAT - 1) begin
            if (!mready) begin
              nr = 1;
              mvalue = mw2;
            end
            mrep = 0;
          end else begin
            mrep++;
          end
        end
      end
      mready = nr;
      mb2 = mb1; mb1 = btn;
      mw2 = mw1; mw1 = sw;
    end
  endtask

  // One clock: advance the model on the edge, compare 1 ns later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ready", int'(lif.ready), int'(mready));
    check("value", int'(lif.value), int'(mvalue));
    check("level", int'(lif.level), int'(mL));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Edges (counting the first one as 1) until ready is seen; 0 on timeout
  task automatic wait_pulse(output int k);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      step();
      if (lif.ready) k = i;
    end
  endtask

  task automatic wait_level_low(output int k);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      step();
      if (!lif.level) k = i;
    end
  endtask

  typedef struct {
    bit         b;
    logic [7:0] s;
    int         cycles;
    int         exp_pulses;
    bit         exp_level;
    logic [7:0] exp_value;
  } seg_t;

  seg_t segs[8];

  initial begin
    int k;
    int pulses;
    rst = 1'b1;
    btn = 1'b0;
    sw  = '0;

    segs[0] = '{1'b1, 8'h3C, 4,  0,  1'b1, 8'hA5};
    segs[1] = '{1'b0, 8'h3C, 2,  0,  1'b1, 8'hA5};
    segs[2] = '{1'b1, 8'h3C, 6,  AR, 1'b1, (AR == 1) ? 8'h3C : 8'hA5};
    segs[3] = '{1'b0, 8'h3C, 10, 0,  1'b0, (AR == 1) ? 8'h3C : 8'hA5};
    segs[4] = '{1'b1, 8'h3C, 9,  1,  1'b1, 8'h3C};
    segs[5] = '{1'b0, 8'h3C, 12, 0,  1'b0, 8'h3C};
    segs[6] = '{1'b1, 8'h77, 2,  0,  1'b0, 8'h3C};
    segs[7] = '{1'b0, 8'h77, 5,  0,  1'b0, 8'h3C};

    // Reset state
    steps(3);
    check("rst_ready", int'(lif.ready), 0);
    check("rst_value", int'(lif.value), 0);
    check("rst_level", int'(lif.level), 0);

    // Clean press
    rst = 1'b0;
    sw  = 8'hA5;
    steps(3);
    btn = 1'b1;
    wait_pulse(k);
    check("press_latency", k, 7);
    check("press_value", int'(lif.value), 8'hA5);
    check("press_level", int'(lif.level), 1);
    step();
    check("press_single", int'(lif.ready), 0);

    // Directed segments: switch change while held, release glitch, release,
    // new press with new switch value, short rising glitch
    for (int i = 0; i < 8; i++) begin
      btn = segs[i].b;
      sw  = segs[i].s;
      pulses = 0;
      for (int c = 0; c < segs[i].cycles; c++) begin
        step();
        if (lif.ready) pulses++;
      end
      check($sformatf("seg%0d_pulses", i), pulses, segs[i].exp_pulses);
      check($sformatf("seg%0d_level", i), int'(lif.level), int'(segs[i].exp_level));
      check($sformatf("seg%0d_value", i), int'(lif.value), int'(segs[i].exp_value));
    end

    // Press/release latency
    sw  = 8'h11;
    btn = 1'b1;
    wait_pulse(k);
    check("press2_latency", k, 7);
    btn = 1'b0;
    wait_level_low(k);
    check("release_latency", k, 7);
    steps(4);

    // Bounce: high 3, low 1, then steady high
    sw  = 8'h5A;
    btn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) btn = 1'b0;
      step();
      if (lif.ready) pulses++;
    end
    btn = 1'b1;
    wait_pulse(k);
    check("bounce_pulses", pulses, 0);
    check("bounce_latency", k, 7);
    check("bounce_value", int'(lif.value), 8'h5A);
    btn = 1'b0;
    steps(12);

    // Reset during rising check with button held
    btn = 1'b1;
    steps(4);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (lif.ready) pulses++;
    end
    check("midrst_pulses", pulses, 0);
    check("midrst_value", int'(lif.value), 0);
    check("midrst_level", int'(lif.level), 0);
    rst = 1'b0;
    wait_pulse(k);
    check("midrst_latency", k, 7);

    // Held button: auto-repeat pulses (or none without the feature)
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (lif.ready) pulses++;
    end
    check("hold_extra_pulses", pulses, 3 * AR);
    btn = 1'b0;
    steps(12);

    // Randomised runs with occasional reset, checked cycle by cycle
    for (int seg = 0; seg < 80; seg++) begin
      btn = 1'($urandom_range(1, 0));
      sw  = 8'($urandom);
      rst = ($urandom_range(39, 0) == 0);
      steps(int'($urandom_range(STABLE + 4, 1)));
      rst = 1'b0;
    end
    steps(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
